mudi_issue_ctrl: RTL

Issue and stall controller between the D/E pipeline registers and the multiply/divide unit. It decodes the E-stage md-class operation into the unit's control strobes (start, mudiOp, hiWrite/loWrite, hiRead/loRead). It generates the D-stage stall for md-class instructions while the unit is occupied. It also keeps a shadow occupancy FSM, a busy-mismatch flag and a saturating stall-cycle counter for verification and performance monitoring.

---
 rtl/mudi_issue_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/mudi_issue_ctrl.sv
// Multiply/divide issue and stall controller: decodes the E-stage md op into unit strobes,
// stalls D-stage md ops while the unit is occupied, and tracks a shadow occupancy FSM.
module mudi_issue_ctrl #(
   parameter int unsigned MUL_CYC = 5,
   parameter int unsigned DIV_CYC = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        d_md_class,
   input  logic        e_valid,
   input  logic [3:0]  e_md_op,
   input  logic        m_flush,
   input  logic        mudi_busy,
   output logic        start,
   output logic [2:0]  mudiOp,
   output logic        hiWrite,
   output logic        loWrite,
   output logic        hiRead,
   output logic        loRead,
   output logic        stall_d,
   output logic        busy_shadow,
   output logic        mismatch,
   output logic [31:0] stall_cycles
);

   localparam int unsigned CW = 4;
   localparam int unsigned SW = 32;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0]    q;

   // Strobe decode; reads bypass the flush qualification since they have no side effect.
   always_comb begin
      q       = (e_valid && !m_flush) ? e_md_op : 4'd0;
      start   = (q >= 4'd1) && (q <= 4'd4);
      mudiOp  = start ? 3'(q - 4'd1) : 3'd0;
      hiWrite = (q == 4'd7);
      loWrite = (q == 4'd8);
      hiRead  = e_valid && (e_md_op == 4'd5);
      loRead  = e_valid && (e_md_op == 4'd6);
      stall_d = d_md_class && (mudi_busy || start);
   end

   // Shadow occupancy: a start always reloads, matching the unit even if issued while busy.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      busy_shadow = start || (state != IDLE);
      if (start) begin
         if (q <= 4'd2) begin
            state_nx = MUL;
            cnt_nx   = CW'(MUL_CYC);
         end else begin
            state_nx = DIV;
            cnt_nx   = CW'(DIV_CYC);
         end
      end else if (state != IDLE) begin
         if (cnt == CW'(1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end else begin
            cnt_nx   = cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         mismatch     <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         mismatch <= mismatch | (busy_shadow != mudi_busy);
         if (stall_d && (stall_cycles != {SW{1'b1}}))
            stall_cycles <= stall_cycles + SW'(1);
      end
   end

endmodule
